// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op encoding and default latencies.
package mdu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] MDU_NONE  = 3'd0;
    localparam logic [OP_W-1:0] MDU_MULT  = 3'd1;
    localparam logic [OP_W-1:0] MDU_MULTU = 3'd2;
    localparam logic [OP_W-1:0] MDU_DIV   = 3'd3;
    localparam logic [OP_W-1:0] MDU_DIVU  = 3'd4;
    localparam logic [OP_W-1:0] MDU_MTHI  = 3'd5;
    localparam logic [OP_W-1:0] MDU_MTLO  = 3'd6;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: produces the HI/LO pair an op will commit, including
// the divide-by-zero (keep current HI/LO) and INT_MIN / -1 overflow cases.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0] i_op,
    input  logic [31:0]     i_rs,
    input  logic [31:0]     i_rt,
    input  logic [31:0]     i_cur_hi,
    input  logic [31:0]     i_cur_lo,
    output logic [31:0]     o_res_hi,
    output logic [31:0]     o_res_lo
);

    logic signed [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic signed [31:0] w_squot;
    logic signed [31:0] w_srem;
    logic        [31:0] w_uquot;
    logic        [31:0] w_urem;
    logic               w_div_zero;
    logic               w_div_ovf;

    assign w_sprod    = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
    assign w_uprod    = {32'd0, i_rs} * {32'd0, i_rt};
    assign w_squot    = $signed(i_rs) / $signed(i_rt);
    assign w_srem     = $signed(i_rs) % $signed(i_rt);
    assign w_uquot    = i_rs / i_rt;
    assign w_urem     = i_rs % i_rt;
    assign w_div_zero = (i_rt == 32'd0);
    assign w_div_ovf  = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);

    // Anything that is not a real multiply/divide result leaves HI/LO as they are.
    always_comb begin
        o_res_hi = i_cur_hi;
        o_res_lo = i_cur_lo;
        case (i_op)
            MDU_MULT: begin
                o_res_hi = w_sprod[63:32];
                o_res_lo = w_sprod[31:0];
            end
            MDU_MULTU: begin
                o_res_hi = w_uprod[63:32];
                o_res_lo = w_uprod[31:0];
            end
            MDU_DIV: begin
                if (w_div_ovf) begin
                    o_res_hi = 32'd0;
                    o_res_lo = 32'h8000_0000;
                end else if (!w_div_zero) begin
                    o_res_hi = w_srem;
                    o_res_lo = w_squot;
                end
            end
            MDU_DIVU: begin
                if (!w_div_zero) begin
                    o_res_hi = w_urem;
                    o_res_lo = w_uquot;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mips_mdu_ctrl.sv
// MDU sequencer: busy counter, pending result, HI/LO commit and D-stage stall request.
// Optional flush input i_cancel is present when MIPS_MDU_CANCEL_EN is defined.
module mips_mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_e_valid,
    input  logic [OP_W-1:0] i_e_op,
    input  logic [31:0]     i_rs,
    input  logic [31:0]     i_rt,
    input  logic            i_d_md,
`ifdef MIPS_MDU_CANCEL_EN
    input  logic            i_cancel,
`endif
    output logic            o_busy,
    output logic            o_stall,
    output logic [31:0]     o_hi,
    output logic [31:0]     o_lo,
    output logic            o_start_err
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_pend_hi;
    logic [31:0]      r_pend_lo;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_start_err;

    logic             w_start;
    logic             w_is_div;
    logic             w_busy;
    logic             w_cancel;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;

    assign w_start  = i_e_valid && ((i_e_op == MDU_MULT) || (i_e_op == MDU_MULTU) ||
                                    (i_e_op == MDU_DIV)  || (i_e_op == MDU_DIVU));
    assign w_is_div = (i_e_op == MDU_DIV) || (i_e_op == MDU_DIVU);
    assign w_busy   = (r_cnt != '0);

`ifdef MIPS_MDU_CANCEL_EN
    assign w_cancel = i_cancel;
`else
    assign w_cancel = 1'b0;
`endif

    mdu_arith u_arith (
        .i_op     (i_e_op),
        .i_rs     (i_rs),
        .i_rt     (i_rt),
        .i_cur_hi (r_hi),
        .i_cur_lo (r_lo),
        .o_res_hi (w_res_hi),
        .o_res_lo (w_res_lo)
    );

    // Starts and MTHI/MTLO are only accepted when idle; a busy cycle either counts down or is cancelled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_pend_hi   <= 32'd0;
            r_pend_lo   <= 32'd0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_start_err <= 1'b0;
        end else if (w_busy) begin
            if (w_start) begin
                r_start_err <= 1'b1;
            end
            if (w_cancel) begin
                r_cnt     <= '0;
                r_pend_hi <= 32'd0;
                r_pend_lo <= 32'd0;
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end
        end else if (i_e_valid && !w_cancel) begin
            if (w_start) begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_cnt     <= w_is_div ? DIV_LOAD : MULT_LOAD;
            end else if (i_e_op == MDU_MTHI) begin
                r_hi <= i_rs;
            end else if (i_e_op == MDU_MTLO) begin
                r_lo <= i_rs;
            end
        end
    end

    assign o_busy      = w_busy;
    assign o_stall     = i_d_md && (w_start || w_busy);
    assign o_hi        = r_hi;
    assign o_lo        = r_lo;
    assign o_start_err = r_start_err;

endmodule

// File: tb/tb_mips_mdu_ctrl.sv
// Self-checking bench for mips_mdu_ctrl: directed scenarios followed by random traffic,
// all checked against an arithmetic reference model of HI/LO, busy time and stall.
module tb_mips_mdu_ctrl;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        eValid;
    logic [2:0]  eOp;
    logic [31:0] rsVal;
    logic [31:0] rtVal;
    logic        dMd;
    logic        cancel;
    logic        busy;
    logic        stall;
    logic [31:0] hiOut;
    logic [31:0] loOut;
    logic        startErr;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model state
    logic [31:0] mHi;
    logic [31:0] mLo;
    logic [63:0] mPend;
    int          mBusyLeft;
    logic        mErr;

    mips_mdu_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .i_e_valid   (eValid),
        .i_e_op      (eOp),
        .i_rs        (rsVal),
        .i_rt        (rtVal),
        .i_d_md      (dMd),
`ifdef MIPS_MDU_CANCEL_EN
        .i_cancel    (cancel),
`endif
        .o_busy      (busy),
        .o_stall     (stall),
        .o_hi        (hiOut),
        .o_lo        (loOut),
        .o_start_err (startErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic isMdStart(input logic v, input logic [2:0] op);
        return v && (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    // Result as {HI, LO}, computed with 64-bit integer arithmetic
    function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] rs,
                                              input logic [31:0] rt, input logic [31:0] curHi,
                                              input logic [31:0] curLo);
        longint a;
        longint b;
        longint q;
        longint r;
        logic [63:0] u;
        case (op)
            OP_MULT: begin
                a = $signed(rs);
                b = $signed(rt);
                q = a * b;
                return q;
            end
            OP_MULTU: begin
                u = {32'd0, rs} * {32'd0, rt};
                return u;
            end
            OP_DIV: begin
                if (rt == 32'd0) return {curHi, curLo};
                a = $signed(rs);
                b = $signed(rt);
                q = a / b;
                r = a % b;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (rt == 32'd0) return {curHi, curLo};
                a = {32'd0, rs};
                b = {32'd0, rt};
                q = a / b;
                r = a % b;
                return {r[31:0], q[31:0]};
            end
            default: return {curHi, curLo};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelEdge(input logic rst, input logic v, input logic [2:0] op,
                             input logic [31:0] rs, input logic [31:0] rt, input logic cxl);
        if (rst) begin
            mHi = 0; mLo = 0; mPend = 0; mBusyLeft = 0; mErr = 0;
        end else if (mBusyLeft > 0) begin
            if (isMdStart(v, op)) mErr = 1'b1;
            if (cxl) begin
                mBusyLeft = 0;
            end else begin
                mBusyLeft--;
                if (mBusyLeft == 0) begin
                    mHi = mPend[63:32];
                    mLo = mPend[31:0];
                end
            end
        end else if (v && !cxl) begin
            if (isMdStart(v, op)) begin
                mPend     = refResult(op, rs, rt, mHi, mLo);
                mBusyLeft = (op == OP_DIV || op == OP_DIVU) ? DIV_LAT : MULT_LAT;
            end else if (op == OP_MTHI) begin
                mHi = rs;
            end else if (op == OP_MTLO) begin
                mLo = rs;
            end
        end
    endtask

    // One clock cycle: drive inputs, check the combinational stall, clock, then check state.
    task automatic applyStimulus(input logic rst, input logic v, input logic [2:0] op,
                                 input logic [31:0] rs, input logic [31:0] rt,
                                 input logic dmd, input logic cxl);
        logic expStall;
        reset  = rst;
        eValid = v;
        eOp    = op;
        rsVal  = rs;
        rtVal  = rt;
        dMd    = dmd;
        cancel = cxl;
        #1;
        expStall = dmd && (isMdStart(v, op) || (mBusyLeft > 0));
        checkOutput("stall", stall, expStall);
        @(posedge clk);
        modelEdge(rst, v, op, rs, rt, cxl);
        #1;
        checkOutput("busy", busy, (mBusyLeft > 0));
        checkOutput("hi", hiOut, mHi);
        checkOutput("lo", loOut, mLo);
        checkOutput("start_err", startErr, mErr);
    endtask

    task automatic idleCycles(input int n, input logic dmd);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 32'd0, dmd, 1'b0);
    endtask

    initial begin
        mHi = 0; mLo = 0; mPend = 0; mBusyLeft = 0; mErr = 0;
        reset = 1'b1; eValid = 1'b0; eOp = OP_NONE; rsVal = 0; rtVal = 0; dMd = 1'b0; cancel = 1'b0;

        applyStimulus(1'b1, 1'b0, OP_NONE, 0, 0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, OP_NONE, 0, 0, 1'b0, 1'b0);
        checkOutput("reset_hi", hiOut, 32'd0);
        checkOutput("reset_busy", busy, 1'b0);

        // MULT -2 * 3
        applyStimulus(1'b0, 1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        checkOutput("mult_busy_t1", busy, 1'b1);
        for (int i = 2; i <= 6; i++) begin
            applyStimulus(1'b0, 1'b0, OP_NONE, 0, 0, 1'b0, 1'b0);
            checkOutput("mult_busy_window", busy, (i <= 5));
        end
        checkOutput("mult_hi", hiOut, 32'hFFFF_FFFF);
        checkOutput("mult_lo", loOut, 32'hFFFF_FFFA);

        // DIVU 100 / 7 with D-stage MDU instruction waiting
        applyStimulus(1'b0, 1'b1, OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
        for (int i = 1; i <= 11; i++) begin
            dMd = 1'b1;
            #1;
            checkOutput("divu_stall_window", stall, (i <= 10));
            applyStimulus(1'b0, 1'b0, OP_NONE, 0, 0, 1'b1, 1'b0);
        end
        checkOutput("divu_lo", loOut, 32'd14);
        checkOutput("divu_hi", hiOut, 32'd2);

        // Signed DIV, divide by zero, and INT_MIN / -1
        applyStimulus(1'b0, 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idleCycles(10, 1'b0);
        checkOutput("div_lo", loOut, 32'hFFFF_FFFD);
        checkOutput("div_hi", hiOut, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, OP_DIV, 32'd1234, 32'd0, 1'b0, 1'b0);
        idleCycles(9, 1'b0);
        checkOutput("divz_still_busy", busy, 1'b1);
        idleCycles(1, 1'b0);
        checkOutput("divz_busy_done", busy, 1'b0);
        checkOutput("divz_lo", loOut, 32'hFFFF_FFFD);
        checkOutput("divz_hi", hiOut, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idleCycles(10, 1'b0);
        checkOutput("divovf_lo", loOut, 32'h8000_0000);
        checkOutput("divovf_hi", hiOut, 32'd0);

        // MTHI while idle, MTLO and a stray start while busy
        applyStimulus(1'b0, 1'b1, OP_MTHI, 32'h1234_5678, 0, 1'b0, 1'b0);
        checkOutput("mthi_hi", hiOut, 32'h1234_5678);
        checkOutput("mthi_busy", busy, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_MULTU, 32'd1, 32'd1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_MTLO, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        checkOutput("mtlo_busy_lo", loOut, 32'h8000_0000);
        applyStimulus(1'b0, 1'b1, OP_DIV, 32'd9, 32'd3, 1'b0, 1'b0);
        checkOutput("start_while_busy_err", startErr, 1'b1);
        idleCycles(4, 1'b0);
        checkOutput("multu_lo", loOut, 32'd1);
        checkOutput("multu_hi", hiOut, 32'd0);

        // Reset in the third busy cycle of a MULT
        applyStimulus(1'b0, 1'b1, OP_MULT, 32'd7, 32'd9, 1'b0, 1'b0);
        idleCycles(2, 1'b0);
        applyStimulus(1'b1, 1'b0, OP_NONE, 0, 0, 1'b0, 1'b0);
        checkOutput("rst_mid_busy", busy, 1'b0);
        checkOutput("rst_mid_hi", hiOut, 32'd0);
        checkOutput("rst_mid_lo", loOut, 32'd0);
        idleCycles(5, 1'b0);
        checkOutput("rst_no_late_commit", loOut, 32'd0);

`ifdef MIPS_MDU_CANCEL_EN
        applyStimulus(1'b0, 1'b1, OP_MTHI, 32'hAAAA_0000, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_MTLO, 32'h0000_BBBB, 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_DIV, 32'd50, 32'd3, 1'b0, 1'b0);
        idleCycles(3, 1'b0);
        applyStimulus(1'b0, 1'b0, OP_NONE, 0, 0, 1'b0, 1'b1);
        checkOutput("cancel_busy", busy, 1'b0);
        idleCycles(8, 1'b0);
        checkOutput("cancel_hi", hiOut, 32'hAAAA_0000);
        checkOutput("cancel_lo", loOut, 32'h0000_BBBB);
        applyStimulus(1'b0, 1'b1, OP_MTHI, 32'h5555_5555, 0, 1'b0, 1'b1);
        checkOutput("cancel_mthi", hiOut, 32'hAAAA_0000);
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            logic        rRst;
            logic        rV;
            logic [2:0]  rOp;
            logic [31:0] rRs;
            logic [31:0] rRt;
            logic        rDmd;
            logic        rCxl;
            rRst = ($urandom_range(99) == 0);
            rV   = ($urandom_range(3) != 0);
            if (mBusyLeft > 0 && $urandom_range(9) != 0)
                rOp = ($urandom_range(1) == 1) ? OP_NONE : 3'($urandom_range(6, 5));
            else
                rOp = 3'($urandom_range(6));
            case ($urandom_range(3))
                0:       rRs = 32'h8000_0000;
                1:       rRs = 32'($urandom_range(20));
                default: rRs = $urandom;
            endcase
            case ($urandom_range(4))
                0:       rRt = 32'd0;
                1:       rRt = 32'hFFFF_FFFF;
                2:       rRt = 32'($urandom_range(9, 1));
                default: rRt = $urandom;
            endcase
            rDmd = 1'($urandom_range(1));
            rCxl = 1'b0;
`ifdef MIPS_MDU_CANCEL_EN
            rCxl = ($urandom_range(19) == 0);
`endif
            applyStimulus(rRst, rV, rOp, rRs, rRt, rDmd, rCxl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
